// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: eight logic operations, an optional accumulator
// as the left operand, and one valid/ready pipeline stage with zero/parity flags.
module logic_unit_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NOR   = 3'b011,
      OP_NAND  = 3'b100,
      OP_XNOR  = 3'b101,
      OP_ANDN  = 3'b110,
      OP_PASSB = 3'b111
   } op_e;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic             r_zero;
   logic             r_parity;
   logic [WIDTH-1:0] r_acc;

   logic             w_accept;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_f;

   // A result slot frees up either when it is empty or when it drains this cycle.
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // In accumulate mode a is never selected, so an undriven a cannot reach w_f.
   assign w_x = acc_mode ? (acc_clear ? '0 : r_acc) : a;

   // NOTE: w_f gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_f = b;
      case (op_e'(op))
         OP_AND:   w_f = w_x & b;
         OP_OR:    w_f = w_x | b;
         OP_XOR:   w_f = w_x ^ b;
         OP_NOR:   w_f = ~(w_x | b);
         OP_NAND:  w_f = ~(w_x & b);
         OP_XNOR:  w_f = ~(w_x ^ b);
         OP_ANDN:  w_f = w_x & ~b;
         OP_PASSB: w_f = b;
         default:  w_f = b;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_zero      <= 1'b0;
         r_parity    <= 1'b0;
         r_acc       <= '0;
      end else if (w_accept) begin
         r_out       <= w_f;
         r_zero      <= (w_f == '0);
         r_parity    <= ^w_f;
         r_out_valid <= 1'b1;
         r_acc       <= w_f;
      end else begin
         if (out_ready)
            r_out_valid <= 1'b0;
         if (acc_clear)
            r_acc <= '0;
      end
   end

   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign zero      = r_zero;
   assign parity    = r_parity;
   assign acc       = r_acc;

endmodule
